fft_sram_loader: RTL and testbench
==================================

# fft_sram_loader

Front-end stage of the FFT datapath. Accepts a stream of 32-bit complex samples over a valid/ready handshake, packs four samples per 128-bit line, writes one frame of N points into the shared 256 x 128 sample SRAM, then starts `fft_top` and holds it running until it reports done. The block owns the SRAM write port while loading and yields it to `fft_top` while the FFT runs.

## Interface
Parameters:
- `SAMPLE_W`, 32: complex sample width, {re[15:0], im[15:0]}.
- `LINE_W`, 128: SRAM line width, always 4 x `SAMPLE_W`.
- `ADDR_W`, 8: SRAM address width (256 lines).

Ports:
- `clk`  in  1  clock; all state updates on posedge.
- `rstn`  in  1  reset, synchronous, active-low.
- `i_point_config`  in  3  frame size code; N = 8 << code (8..1024 points, 2..256 lines).
- `i_valid`  in  1  upstream sample valid.
- `i_sample`  in  32  upstream sample.
- `o_ready`  out  1  loader can accept a sample.
- `o_waddress`  out  8  SRAM write line address.
- `o_wdata`  out  128  SRAM write line.
- `o_write_enable`  out  1  SRAM write strobe, one cycle per line.
- `o_working`  out  1  drives `fft_top.i_working`.
- `i_fft_done`  in  1  from `fft_top.o_fft_done`.
- `o_busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, FILL, START, RUN, RELEASE.
- A handshake occurs on a posedge when `i_valid && o_ready`.
- `o_ready` is 1 in IDLE and FILL and 0 in START, RUN and RELEASE.
- IDLE: on the first handshake, latch `i_point_config` into `cfg_q`, treat that sample as sample 0, and move to FILL. `cfg_q` is held for the whole frame; changes to `i_point_config` mid-frame are ignored.
- Packing: sample index k goes to lane k%4 of line k/4. Lane 0 is bits [127:96], lane 3 is bits [31:0]. The line address is k/4, starting at 0 and incrementing by 1 (no base offset). The address counter has width `ADDR_W`; a 1024-point frame ends at address 255 with no wrap.
- FILL: on the handshake of the last sample (k = N-1), move to START.
- START: lasts one cycle and carries the write of the final line.
- RUN: `o_working` is 1. Stay until `i_fft_done` is 1, then move to RELEASE.
- RELEASE: `o_working` is 0. Stay until `i_fft_done` drops, then return to IDLE. This guarantees `fft_top` sees `i_working` low before the next frame.
- `i_fft_done` is ignored in IDLE, FILL and START.
- Partial lines never occur, because N is always a multiple of 4.
- `o_write_enable` is never 1 in RUN or RELEASE.

## Timing
- Reset values: `o_ready`=0 during reset and 1 in the first cycle after reset; `o_waddress`=0, `o_wdata`=0, `o_write_enable`=0, `o_working`=0, `o_busy`=0. Lane counter, line counter and `cfg_q` are cleared and the state is IDLE.
- Write outputs are registered. When the handshake of lane 3 happens at edge t, the cycle after t has `o_write_enable`=1, `o_waddress`=line and `o_wdata`=packed line. `o_write_enable` lasts exactly one cycle.
- Back-to-back handshakes give one write every 4 cycles at full throughput. Gaps in `i_valid` only stretch the time between writes.
- After the last handshake at edge t: the cycle t..t+1 is START and carries the final write; from edge t+1, `o_working`=1. The final SRAM write therefore commits at the same edge that `o_working` rises, and is visible before the FFT's first read.
- Edge where `i_fft_done` is first seen high: `o_working` is 0 from that edge onward.
- `rstn` low at any point, including mid-FILL or mid-RUN, aborts at the next edge. Partially packed data is discarded, `o_working` drops immediately, and no write is issued.

## Test plan
- Reset: hold `rstn`=0 for 5 cycles with `i_valid`=1 -> all outputs 0 and no writes; `o_ready`=1 one cycle after release.
- 8-point frame, `i_point_config`=0, samples 0x00000000..0x00000007 back-to-back -> write addr 0 = 00000000_00000001_00000002_00000003, addr 1 = 00000004_..._00000007; `o_working` rises 1 cycle after the addr-1 write strobe; exactly 2 writes.
- 1024-point frame (cfg=7) with random `i_valid` gaps -> 256 writes at addresses 0..255 in order, data matches the packed model, `o_ready`=0 from START on.
- Done handshake: in RUN, assert `i_fft_done` for 3 cycles, then 0 -> `o_working` falls the edge after done is seen; `o_busy` falls, `o_ready` rises and IDLE is re-entered only after done drops. A second frame then loads correctly starting from addr 0.
- Config change mid-frame: start cfg=1 (16 points), switch to cfg=3 after 5 samples -> exactly 4 writes, then RUN.
- Reset mid-FILL after 6 samples of a 16-point frame -> no further writes, `o_working` stays 0; the next frame starts at addr 0, lane 0.

Source files
------------

// File: rtl/fft_sram_loader.sv
// FFT front-end loader: packs a stream of complex samples four per line into the
// sample SRAM, then starts fft_top and holds it running until it reports done.
module fft_sram_loader #(
  parameter int SAMPLE_W = 32,
  parameter int LINE_W   = 128,
  parameter int ADDR_W   = 8
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [2:0]          i_point_config,
  input  logic                i_valid,
  input  logic [SAMPLE_W-1:0] i_sample,
  output logic                o_ready,
  output logic [ADDR_W-1:0]   o_waddress,
  output logic [LINE_W-1:0]   o_wdata,
  output logic                o_write_enable,
  output logic                o_working,
  input  logic                i_fft_done,
  output logic                o_busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_START,
    S_RUN,
    S_RELEASE
  } state_t;

  state_t              state_reg, state_next;
  logic [2:0]          cfg_reg;
  logic [1:0]          lane_cnt_reg;
  logic [ADDR_W-1:0]   line_cnt_reg;
  logic                handshake;
  logic [2:0]          cfg_eff;
  logic [ADDR_W:0]     line_total;
  logic [ADDR_W:0]     last_line;
  logic                last_sample;

  assign handshake = i_valid && o_ready;

  // The first sample of a frame is taken while still in IDLE, so the live code
  // applies there; afterwards the latched code governs the frame length.
  assign cfg_eff     = (state_reg == S_IDLE) ? i_point_config : cfg_reg;
  assign line_total  = (ADDR_W + 1)'(2) << cfg_eff;
  assign last_line   = line_total - (ADDR_W + 1)'(1);
  assign last_sample = handshake && (lane_cnt_reg == 2'd3) &&
                       (line_cnt_reg == last_line[ADDR_W-1:0]);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:    if (handshake) state_next = S_FILL;
      S_FILL:    if (last_sample) state_next = S_START;
      S_START:   state_next = S_RUN;
      S_RUN:     if (i_fft_done) state_next = S_RELEASE;
      S_RELEASE: if (!i_fft_done) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  // Lanes 0..2 are held until lane 3 arrives; lane 3 goes straight to the line.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    logic [SAMPLE_W-1:0] held_reg;
    always_ff @(posedge clk) begin
      if (!rstn) begin
        held_reg <= '0;
      end else if (handshake && (lane_cnt_reg == 2'(gi))) begin
        held_reg <= i_sample;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg      <= S_IDLE;
      cfg_reg        <= '0;
      lane_cnt_reg   <= '0;
      line_cnt_reg   <= '0;
      o_ready        <= 1'b0;
      o_waddress     <= '0;
      o_wdata        <= '0;
      o_write_enable <= 1'b0;
      o_working      <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      state_reg      <= state_next;
      o_ready        <= (state_next == S_IDLE) || (state_next == S_FILL);
      o_working      <= (state_next == S_RUN);
      o_busy         <= (state_next != S_IDLE);
      o_write_enable <= 1'b0;
      if (handshake) begin
        if (state_reg == S_IDLE) cfg_reg <= i_point_config;
        lane_cnt_reg <= lane_cnt_reg + 2'd1;
        if (lane_cnt_reg == 2'd3) begin
          o_wdata        <= {g_lane[0].held_reg, g_lane[1].held_reg,
                             g_lane[2].held_reg, i_sample};
          o_waddress     <= line_cnt_reg;
          o_write_enable <= 1'b1;
          line_cnt_reg   <= last_sample ? '0 : line_cnt_reg + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fft_sram_loader.sv
// Directed and randomized frames against a packed-line model of the SRAM image.
module tb_fft_sram_loader;

  logic         clk = 1'b0;
  logic         rstn;
  logic [2:0]   i_point_config;
  logic         i_valid;
  logic [31:0]  i_sample;
  logic         o_ready;
  logic [7:0]   o_waddress;
  logic [127:0] o_wdata;
  logic         o_write_enable;
  logic         o_working;
  logic         i_fft_done;
  logic         o_busy;

  int errors = 0;
  int checks = 0;

  logic [31:0]  smp[$];
  logic [7:0]   wr_addr[$];
  logic [127:0] wr_data[$];
  int           illegal_we = 0;

  always #5 clk = ~clk;

  fft_sram_loader dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_point_config (i_point_config),
    .i_valid        (i_valid),
    .i_sample       (i_sample),
    .o_ready        (o_ready),
    .o_waddress     (o_waddress),
    .o_wdata        (o_wdata),
    .o_write_enable (o_write_enable),
    .o_working      (o_working),
    .i_fft_done     (i_fft_done),
    .o_busy         (o_busy)
  );

  always @(negedge clk) begin
    if (o_write_enable === 1'b1) begin
      wr_addr.push_back(o_waddress);
      wr_data.push_back(o_wdata);
      if (o_working !== 1'b0) illegal_we++;
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] s, input logic [2:0] cfg, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk);
      i_valid = 1'b0;
    end
    @(negedge clk);
    i_valid = 1'b1;
    i_sample = s;
    i_point_config = cfg;
    n = 0;
    while (o_ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("push_timeout", 0, 1);
    smp.push_back(s);
  endtask

  task automatic wait_working();
    int n = 0;
    while (o_working !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("working_rise", o_working, 1);
  endtask

  task automatic finish_frame();
    int n = 0;
    @(negedge clk);
    i_fft_done = 1'b1;
    repeat (2) @(negedge clk);
    i_fft_done = 1'b0;
    while (o_busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("busy_fall", o_busy, 0);
  endtask

  // Line j of the SRAM image holds samples 4j..4j+3, earliest in the top lane.
  task automatic check_writes(input string tag, input int lines);
    logic [127:0] exp;
    check({tag, "_count"}, wr_addr.size(), lines);
    for (int j = 0; j < lines && j < wr_addr.size(); j++) begin
      exp = {smp[4*j], smp[4*j+1], smp[4*j+2], smp[4*j+3]};
      if (wr_addr[j] !== 8'(j) || wr_data[j] !== exp) begin
        check({tag, "_addr"}, wr_addr[j], j);
        check({tag, "_data"}, wr_data[j], exp);
      end else begin
        checks++;
      end
    end
    $display("frame %s: %0d lines written, expected %0d", tag, wr_addr.size(), lines);
  endtask

  task automatic clear_model();
    smp.delete();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rstn = 1'b0;
    i_valid = 1'b1;
    i_sample = 32'hDEAD_BEEF;
    i_point_config = 3'd0;
    i_fft_done = 1'b0;

    // Reset held with valid asserted
    repeat (5) begin
      @(negedge clk);
      check("rst_outputs", {o_ready, o_write_enable, o_working, o_busy, o_waddress}, 0);
    end
    check("rst_wdata", o_wdata, 0);
    rstn = 1'b1;
    i_valid = 1'b0;
    @(negedge clk);
    check("rst_ready_after", o_ready, 1);
    check("rst_no_writes", wr_addr.size(), 0);

    // 8-point frame, back-to-back
    clear_model();
    for (int k = 0; k < 8; k++) push(32'(k), 3'd0, 0);
    @(negedge clk);
    i_valid = 1'b0;
    check("p8_start_we", o_write_enable, 1);
    check("p8_start_addr", o_waddress, 1);
    check("p8_start_working", o_working, 0);
    check("p8_start_ready", o_ready, 0);
    @(negedge clk);
    check("p8_run_working", o_working, 1);
    check("p8_run_we", o_write_enable, 0);
    check("p8_line0", wr_data[0], 128'h00000000_00000001_00000002_00000003);
    check_writes("p8", 2);

    // Done handshake timing
    @(negedge clk);
    i_fft_done = 1'b1;
    @(negedge clk);
    check("done_working_fall", o_working, 0);
    check("done_busy_hold", o_busy, 1);
    @(negedge clk);
    @(negedge clk);
    i_fft_done = 1'b0;
    check("release_ready", o_ready, 0);
    check("release_busy", o_busy, 1);
    @(negedge clk);
    check("idle_busy", o_busy, 0);
    check("idle_ready", o_ready, 1);

    // 1024-point frame, random samples and gaps
    clear_model();
    for (int k = 0; k < 1024; k++)
      push($urandom, 3'd7, ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
    @(negedge clk);
    i_valid = 1'b0;
    check("p1024_start_ready", o_ready, 0);
    check("p1024_last_addr", o_waddress, 8'd255);
    wait_working();
    repeat (3) @(negedge clk);
    check("p1024_ready_run", o_ready, 0);
    check_writes("p1024", 256);
    finish_frame();

    // Second 8-point frame after done, random data
    clear_model();
    for (int k = 0; k < 8; k++) push($urandom, 3'd0, 0);
    @(negedge clk);
    i_valid = 1'b0;
    wait_working();
    check_writes("second", 2);
    finish_frame();

    // Config changes mid-frame are ignored
    clear_model();
    for (int k = 0; k < 16; k++) push($urandom, (k < 5) ? 3'd1 : 3'd3, 0);
    @(negedge clk);
    i_valid = 1'b0;
    wait_working();
    @(negedge clk);
    check_writes("cfgchg", 4);
    finish_frame();

    // Reset in the middle of a 16-point frame
    clear_model();
    for (int k = 0; k < 6; k++) push($urandom, 3'd1, 0);
    @(negedge clk);
    i_valid = 1'b0;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_writes", wr_addr.size(), 1);
    check("midrst_working", o_working, 0);
    check("midrst_busy", o_busy, 0);

    clear_model();
    for (int k = 0; k < 8; k++) push($urandom, 3'd0, 0);
    @(negedge clk);
    i_valid = 1'b0;
    wait_working();
    check_writes("after_rst", 2);
    finish_frame();

    check("no_we_while_working", illegal_we, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
